// File: rtl/peripheral_bus_arbiter.sv
`default_nettype none
// peripheral_bus_arbiter: round-robin owner of the shared peripheral bus. A grant is
// held for a whole transaction, and a watchdog force-completes stuck transactions.
module peripheral_bus_arbiter #(
  parameter int REQUESTERS = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REQUESTERS-1:0]      req_we,
  input  logic [REQUESTERS-1:0]      req_oe,
  input  logic [24*REQUESTERS-1:0]   req_address,
  input  logic [4*REQUESTERS-1:0]    req_byteSelect,
  input  logic [32*REQUESTERS-1:0]   req_dataWrite,
  output logic [32*REQUESTERS-1:0]   req_dataRead,
  output logic [REQUESTERS-1:0]      req_busy,
  output logic                       peripheralBus_we,
  output logic                       peripheralBus_oe,
  output logic [23:0]                peripheralBus_address,
  output logic [3:0]                 peripheralBus_byteSelect,
  output logic [31:0]                peripheralBus_dataWrite,
  input  logic [31:0]                peripheralBus_dataRead,
  input  logic                       peripheralBus_busy,
  output logic [REQUESTERS-1:0]      grant,
  output logic                       timeout
);

  localparam int IW = $clog2(REQUESTERS);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t                state;
  logic [IW-1:0]         owner;
  logic [IW-1:0]         last_owner;
  logic [IW-1:0]         next_owner;
  logic [15:0]           wd_count;
  logic [REQUESTERS-1:0] req;
  logic                  any_req;
  logic                  owner_req;
  logic                  complete;
  logic                  forced;
  logic                  release_bus;

  assign req         = req_we | req_oe;
  assign any_req     = |req;
  assign owner_req   = |(req & grant);
  assign complete    = (state == OWNED) && owner_req && !peripheralBus_busy;
  assign forced      = (state == OWNED) && owner_req && peripheralBus_busy &&
                       (wd_count == 16'(TIMEOUT));
  assign release_bus = (state == OWNED) && (!owner_req || !peripheralBus_busy || forced);
  assign timeout     = forced;

  // First requester strictly after last_owner, wrapping around.
  always_comb begin
    int            cand;
    logic [IW-1:0] cidx;
    logic          found;
    cand       = 0;
    cidx       = '0;
    found      = 1'b0;
    next_owner = last_owner;
    for (int k = 1; k <= REQUESTERS; k++) begin
      cand = int'(last_owner) + k;
      if (cand >= REQUESTERS) cand = cand - REQUESTERS;
      cidx = IW'(cand);
      if (!found && req[cidx]) begin
        found      = 1'b1;
        next_owner = cidx;
      end
    end
  end

  // grant is one-hot only while OWNED, so an OR-mux over it yields the owner's slice or zero.
  always_comb begin
    peripheralBus_we         = 1'b0;
    peripheralBus_oe         = 1'b0;
    peripheralBus_address    = '0;
    peripheralBus_byteSelect = '0;
    peripheralBus_dataWrite  = '0;
    req_dataRead             = '0;
    req_busy                 = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (grant[i]) begin
        peripheralBus_we         = req_we[i];
        peripheralBus_oe         = req_oe[i];
        peripheralBus_address    = req_address[24*i +: 24];
        peripheralBus_byteSelect = req_byteSelect[4*i +: 4];
        peripheralBus_dataWrite  = req_dataWrite[32*i +: 32];
        if (forced)
          req_dataRead[32*i +: 32] = 32'hFFFF_FFFF;
        else if (complete)
          req_dataRead[32*i +: 32] = peripheralBus_dataRead;
      end
      req_busy[i] = req[i] & ~(grant[i] & (~peripheralBus_busy | forced));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      last_owner <= IW'(REQUESTERS - 1);
      wd_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state    <= OWNED;
            grant    <= REQUESTERS'(1) << next_owner;
            owner    <= next_owner;
            wd_count <= '0;
          end
        end
        OWNED: begin
          if (release_bus) begin
            state      <= IDLE;
            grant      <= '0;
            last_owner <= owner;
          end else if (peripheralBus_busy) begin
            wd_count <= wd_count + 16'd1;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/peripheral_bus_arbiter.md
# peripheral_bus_arbiter

Shares the single peripheral bus, which fans out to the UART and other peripheral blocks, between several bus requesters such as the core and a DMA engine. The arbiter grants the bus to one requester at a time using round-robin order and holds that grant for a whole transaction. Non-owners are stalled through their busy lines. A watchdog force-terminates transactions that a peripheral never completes.

## Interface
- REQUESTERS, 2: number of requester ports (2..8); vectors are packed, requester i occupies slice i.
- TIMEOUT, 255: maximum consecutive cycles the owner may see peripheralBus_busy high before forced termination (1..65535).
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_we  in  REQUESTERS  per-requester write strobe.
- req_oe  in  REQUESTERS  per-requester read strobe.
- req_address  in  24*REQUESTERS  per-requester address.
- req_byteSelect  in  4*REQUESTERS  per-requester byte enables.
- req_dataWrite  in  32*REQUESTERS  per-requester write data.
- req_dataRead  out  32*REQUESTERS  per-requester read data.
- req_busy  out  REQUESTERS  per-requester stall.
- peripheralBus_we, peripheralBus_oe  out  1 each  shared bus strobes.
- peripheralBus_address  out  24  shared address.
- peripheralBus_byteSelect  out  4  shared byte enables.
- peripheralBus_dataWrite  out  32  shared write data.
- peripheralBus_dataRead  in  32  read data from peripherals (already muxed).
- peripheralBus_busy  in  1  OR of peripheral busy lines.
- grant  out  REQUESTERS  one-hot registered owner; all-zero when idle.
- timeout  out  1  one-cycle pulse on forced termination.

## Operation
- Request: req[i] = req_we[i] | req_oe[i]. A requester holds its strobes and fields stable until it sees req_busy[i]=0.
- States: IDLE (grant=0) and OWNED (grant one-hot).
- IDLE: if any req, choose the first requesting index after last_owner in increasing-modulo order. Register grant, enter OWNED next cycle. No request: stay IDLE.
- OWNED: bus outputs are a combinational copy of the owner's slice. Non-owner or IDLE: all bus outputs 0.
- Completion: the cycle with owner req=1 and peripheralBus_busy=0.
  - Owner req_busy=0.
  - Owner req_dataRead = peripheralBus_dataRead.
  - last_owner <= owner, grant <= 0, go to IDLE.
- Abort: owner req drops to 0 while OWNED. Release as for completion; nothing is returned to the requester.
- req_busy[i] = req[i] & ~(grant[i] & ~peripheralBus_busy) during normal operation. A non-requesting port has busy=0.
- req_dataRead[i] = 0 unless i is the completing owner, or the timed-out owner (see below).
- Watchdog: 16-bit counter, cleared on entry to OWNED. It increments each OWNED cycle with peripheralBus_busy=1 and req=1. When the count equals TIMEOUT and busy is still 1, that cycle is a forced completion:
  - owner req_busy=0 and req_dataRead=32'hFFFFFFFF;
  - timeout=1;
  - release as for normal completion.
- Reset: grant=0, state IDLE, last_owner=REQUESTERS-1 (requester 0 wins first), counter=0, timeout=0. Combinational outputs follow these rules, so bus outputs are 0 and req_busy=req.

## Timing
- Arbitration latency: 1 cycle. A request arriving in IDLE at cycle N is granted from N+1; req_busy is 1 at N.
- Zero-wait peripheral: a request made in IDLE at cycle N completes at N+1. Back-to-back transactions from one requester take 2 cycles each, because of the mandatory IDLE cycle after each release.
- Two requesters continuously requesting alternate grants: 0,1,0,1…
- Simultaneous events:
  - A new request arriving in the completion cycle is not considered until the following IDLE cycle.
  - A reset asserted mid-transaction drops the grant in the next cycle, with no timeout pulse.
- Watchdog with TIMEOUT=T: with busy stuck high from the first OWNED cycle, the forced completion occurs on OWNED cycle T+1. The timeout pulse lasts exactly 1 cycle.

## Test plan
- Reset then idle, with all req=0 → grant=0, all bus outputs 0, req_busy=0, timeout=0.
- Single read by requester 0 at 0x000104, peripheral busy=0, dataRead=0xA5A5A5A5:
  - cycle N: req_busy[0]=1;
  - cycle N+1: grant=01, bus_oe=1, address 0x000104, req_busy[0]=0, req_dataRead[0]=0xA5A5A5A5.
- Both requesters issue writes simultaneously after reset; peripheral busy held 3 cycles per transaction → requester 0 served first, then requester 1. req_busy[1] stays 1 throughout requester 0's transaction. Grant sequence is 01,00,10.
- Continuous requests from both for 8 transactions → strict alternation, 4 grants each.
- Owner drops strobes mid-transaction while busy=1 → grant=0 next cycle; the other pending requester is granted the cycle after.
- TIMEOUT=4, busy stuck 1 → forced completion on the 5th OWNED cycle: req_dataRead=0xFFFFFFFF, timeout pulses once, and the next requester is granted afterwards.
